// File: rtl/demux_1t2_64_buf.sv
// Buffered 1-to-2 steering unit: one valid/ready input stream is routed by a per-word
// select bit into two independent first-word-fall-through FIFOs, each with its own output port.
module demux_1t2_64_buf #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        o0_valid,
    input  logic        o0_ready,
    output logic [63:0] o0_data,
    output logic        o1_valid,
    input  logic        o1_ready,
    output logic [63:0] o1_data,
    output logic [AW:0] cnt0,
    output logic [AW:0] cnt1
);
    localparam int          DATA_W = 64;
    localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);

    logic [1:0]             out_ready;
    logic [1:0]             out_valid;
    logic [1:0]             push;
    logic [1:0]             pop;
    logic [1:0][AW:0]       cnt;
    logic [1:0][DATA_W-1:0] head;

    assign out_ready = {o1_ready, o0_ready};

    // Readiness looks only at registered occupancy, so a full channel cannot pass a word
    // through in the same cycle its consumer pops.
    assign in_ready = s ? (cnt[1] != FULL) : (cnt[0] != FULL);

    assign o0_valid = out_valid[0];
    assign o1_valid = out_valid[1];
    assign o0_data  = head[0];
    assign o1_data  = head[1];
    assign cnt0     = cnt[0];
    assign cnt1     = cnt[1];

    generate
        for (genvar k = 0; k < 2; k++) begin : g_ch
            logic [DATA_W-1:0] mem [DEPTH];
            logic [AW-1:0]     wptr;
            logic [AW-1:0]     rptr;
            logic [AW:0]       count;

            assign push[k]      = in_valid && in_ready && (s == 1'(k));
            assign out_valid[k] = (count != '0);
            assign pop[k]       = out_valid[k] && out_ready[k];
            assign cnt[k]       = count;
            assign head[k]      = mem[rptr];

            // Pointers wrap naturally; full/empty come from count alone.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wptr  <= '0;
                    rptr  <= '0;
                    count <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        mem[i] <= '0;
                    end
                end else begin
                    if (push[k]) begin
                        mem[wptr] <= in_data;
                        wptr      <= wptr + 1'b1;
                    end
                    if (pop[k]) begin
                        rptr <= rptr + 1'b1;
                    end
                    case ({push[k], pop[k]})
                        2'b10:   count <= count + 1'b1;
                        2'b01:   count <= count - 1'b1;
                        default: count <= count;
                    endcase
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_demux_1t2_64_buf.sv
// Directed bench for demux_1t2_64_buf: the driver queues expected words per channel,
// and a negedge monitor pops and compares whenever a channel hands a word to its consumer.
module tb_demux_1t2_64_buf;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        o0_valid;
    logic        o0_ready = 1'b0;
    logic [63:0] o0_data;
    logic        o1_valid;
    logic        o1_ready = 1'b0;
    logic [63:0] o1_data;
    logic [2:0]  cnt0;
    logic [2:0]  cnt1;

    int checks = 0;
    int failures = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];

    demux_1t2_64_buf #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n), .s(s), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .o0_valid(o0_valid), .o0_ready(o0_ready), .o0_data(o0_data),
        .o1_valid(o1_valid), .o1_ready(o1_ready), .o1_data(o1_data),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one word on the given channel and record it as expected when it must be accepted.
    task automatic offer(input logic sel, input logic [63:0] d, input logic exp_rdy, input string name);
        s = sel;
        in_valid = 1'b1;
        in_data = d;
        #1;
        chk(name, {63'd0, in_ready}, {63'd0, exp_rdy});
        if (exp_rdy) begin
            if (sel) q1.push_back(d);
            else     q0.push_back(d);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o0_valid && o0_ready) begin
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL o0_unexpected actual=%h expected=none", o0_data);
                end else begin
                    chk("o0_data", o0_data, q0.pop_front());
                end
            end
            if (o1_valid && o1_ready) begin
                if (q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL o1_unexpected actual=%h expected=none", o1_data);
                end else begin
                    chk("o1_data", o1_data, q1.pop_front());
                end
            end
        end
    end

    // Source-stability rule: a stalled word must not change while it is still offered.
    logic        stall_prev = 1'b0;
    logic        s_prev = 1'b0;
    logic [63:0] d_prev = '0;
    always @(posedge clk) begin
        if (rst_n && stall_prev && in_valid && (s !== s_prev || in_data !== d_prev)) begin
            failures++;
            $display("FAIL src_stable actual=%h expected=%h", in_data, d_prev);
        end
        stall_prev <= rst_n && in_valid && !in_ready;
        s_prev     <= s;
        d_prev     <= in_data;
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_o0_valid", {63'd0, o0_valid}, 64'd0);
        chk("rst_o1_valid", {63'd0, o1_valid}, 64'd0);
        chk("rst_cnt0", {61'd0, cnt0}, 64'd0);
        chk("rst_cnt1", {61'd0, cnt1}, 64'd0);
        chk("rst_o0_data", o0_data, 64'h0);

        // Single word to channel 0
        cyc();
        offer(1'b0, 64'hDEAD_BEEF_0000_0001, 1'b1, "single_rdy");
        cyc();
        in_valid = 1'b0;
        #1;
        chk("single_o0_valid", {63'd0, o0_valid}, 64'd1);
        chk("single_o0_data", o0_data, 64'hDEAD_BEEF_0000_0001);
        chk("single_cnt0", {61'd0, cnt0}, 64'd1);
        chk("single_o1_valid", {63'd0, o1_valid}, 64'd0);
        chk("single_cnt1", {61'd0, cnt1}, 64'd0);
        o0_ready = 1'b1;
        cyc();
        o0_ready = 1'b0;
        #1;
        chk("single_drained", {61'd0, cnt0}, 64'd0);

        // Fill channel 1, then drain with word 5 accepted one cycle after the first pop
        for (int i = 1; i <= 4; i++) begin
            offer(1'b1, 64'(i), 1'b1, "fill1_rdy");
            cyc();
        end
        offer(1'b1, 64'h5, 1'b0, "fill1_full_stall");
        chk("fill1_cnt1", {61'd0, cnt1}, 64'd4);
        o1_ready = 1'b1;
        #1;
        chk("fill1_no_passthru", {63'd0, in_ready}, 64'd0);
        cyc();
        chk("fill1_after_pop_cnt", {61'd0, cnt1}, 64'd3);
        chk("fill1_after_pop_rdy", {63'd0, in_ready}, 64'd1);
        q1.push_back(64'h5);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("fill1_pushpop_cnt", {61'd0, cnt1}, 64'd3);
        repeat (3) cyc();
        o1_ready = 1'b0;
        chk("fill1_empty_cnt", {61'd0, cnt1}, 64'd0);
        chk("fill1_empty_valid", {63'd0, o1_valid}, 64'd0);

        // Independence: channel 0 full blocks only s=0 words
        for (int i = 0; i < 4; i++) begin
            offer(1'b0, 64'hA000 + 64'(i), 1'b1, "ind_fill0_rdy");
            cyc();
        end
        o1_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            offer(1'b0, 64'hEEEE, 1'b0, "ind_s0_stall");
            cyc();
            in_valid = 1'b0;
            cyc();
            offer(1'b1, 64'hB000 + 64'(j), 1'b1, "ind_s1_rdy");
            cyc();
            in_valid = 1'b0;
            #1;
            chk("ind_o1_valid", {63'd0, o1_valid}, 64'd1);
            chk("ind_o1_data", o1_data, 64'hB000 + 64'(j));
            cyc();
        end
        o1_ready = 1'b0;
        chk("ind_cnt0_full", {61'd0, cnt0}, 64'd4);
        o0_ready = 1'b1;
        repeat (4) cyc();
        o0_ready = 1'b0;
        chk("ind_cnt0_drained", {61'd0, cnt0}, 64'd0);

        // Simultaneous push/pop at occupancy 2 across pointer wrap
        offer(1'b0, 64'hC000, 1'b1, "pp_pre_rdy");
        cyc();
        offer(1'b0, 64'hC001, 1'b1, "pp_pre_rdy");
        cyc();
        chk("pp_cnt0_start", {61'd0, cnt0}, 64'd2);
        o0_ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            offer(1'b0, 64'hC000 + 64'(i), 1'b1, "pp_rdy");
            cyc();
            chk("pp_cnt0_hold", {61'd0, cnt0}, 64'd2);
        end
        in_valid = 1'b0;
        repeat (2) cyc();
        o0_ready = 1'b0;
        chk("pp_cnt0_drained", {61'd0, cnt0}, 64'd0);

        // Pops against empty FIFOs
        o0_ready = 1'b1;
        o1_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("empty_cnt0", {61'd0, cnt0}, 64'd0);
            chk("empty_cnt1", {61'd0, cnt1}, 64'd0);
            chk("empty_valids", {62'd0, o1_valid, o0_valid}, 64'd0);
        end
        o0_ready = 1'b0;
        o1_ready = 1'b0;

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            offer(1'b0, 64'hD000 + 64'(i), 1'b1, "ar_fill0_rdy");
            cyc();
        end
        for (int i = 0; i < 2; i++) begin
            offer(1'b1, 64'hD100 + 64'(i), 1'b1, "ar_fill1_rdy");
            cyc();
        end
        in_valid = 1'b0;
        s = 1'b0;
        #1;
        chk("ar_pre_cnt0", {61'd0, cnt0}, 64'd3);
        chk("ar_pre_cnt1", {61'd0, cnt1}, 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_o_valids", {62'd0, o1_valid, o0_valid}, 64'd0);
        chk("ar_cnt0", {61'd0, cnt0}, 64'd0);
        chk("ar_cnt1", {61'd0, cnt1}, 64'd0);
        chk("ar_o0_data", o0_data, 64'h0);
        chk("ar_o1_data", o1_data, 64'h0);
        chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        cyc();
        o1_ready = 1'b1;
        offer(1'b1, 64'hF00D_0000_0000_0001, 1'b1, "resume_rdy");
        cyc();
        in_valid = 1'b0;
        #1;
        chk("resume_o1_valid", {63'd0, o1_valid}, 64'd1);
        chk("resume_o1_data", o1_data, 64'hF00D_0000_0000_0001);
        cyc();

        // Bounded wait for the scoreboard to empty
        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) cyc();
        chk("final_q_empty", 64'(q0.size() + q1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
